// File: rtl/cpu_state_seq.sv
// ============================================================================
// cpu_state_seq : multicycle FETCH/EXEC1/EXEC2 sequencer with halt and bus-timeout fault
// Revision      : 1.0
// ============================================================================
`default_nettype none

module cpu_state_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_W        = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               mem_req_i,
  input  logic               waitrequest_i,
  input  logic               halt_i,
  output logic [1:0]         state_o,
  output logic               advance_o,
  output logic               active_o,
  output logic               fault_o,
  output logic [COUNT_W-1:0] instr_count_o,
  output logic [COUNT_W-1:0] stall_count_o
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC1 = 2'd1;
  localparam logic [1:0] EXEC2 = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  // The wait counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned        WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic               active_q, active_d;
  logic               fault_q, fault_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [COUNT_W-1:0] instr_q, instr_d;
  logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic stall;
  logic timeout;
  logic retire;

  assign stall   = mem_req_i & waitrequest_i & (state_q != HALT);
  assign timeout = stall & (wait_q == WAIT_LAST);
  assign retire  = (state_q == EXEC2) & ~stall;

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = HALT;
    end else if (!stall) begin
      case (state_q)
        FETCH:   state_d = EXEC1;
        EXEC1:   state_d = EXEC2;
        EXEC2:   state_d = halt_i ? HALT : FETCH;
        HALT:    state_d = HALT;
        default: state_d = HALT;
      endcase
    end
  end

  always_comb begin
    active_d    = (state_d != HALT);
    fault_d     = fault_q | timeout;
    wait_d      = stall ? (wait_q + WAIT_W'(1)) : '0;
    instr_d     = instr_q;
    stall_cnt_d = stall_cnt_q;
    if (retire && (instr_q != '1)) begin
      instr_d = instr_q + COUNT_W'(1);
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= FETCH;
      active_q    <= 1'b1;
      fault_q     <= 1'b0;
      wait_q      <= '0;
      instr_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      fault_q     <= fault_d;
      wait_q      <= wait_d;
      instr_q     <= instr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state_o       = state_q;
  assign advance_o     = (state_q != HALT) & ~stall;
  assign active_o      = active_q;
  assign fault_o       = fault_q;
  assign instr_count_o = instr_q;
  assign stall_count_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_state_seq.sv
// ============================================================================
// tb_cpu_state_seq : directed scoreboard bench for cpu_state_seq (TIMEOUT_CYCLES=4, COUNT_W=4)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_state_seq;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic [1:0]    st;
    logic          act;
    logic          flt;
    logic [CW-1:0] ic;
    logic [CW-1:0] sc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req = 1'b0;
  logic          waitreq = 1'b0;
  logic          halt = 1'b0;
  logic [1:0]    state;
  logic          advance;
  logic          active;
  logic          fault;
  logic [CW-1:0] icount;
  logic [CW-1:0] scount;

  int checks = 0;
  int errors = 0;

  exp_t q[$];

  // reference model
  int m_state, m_wait, m_ic, m_sc;
  logic m_fault;

  cpu_state_seq #(.TIMEOUT_CYCLES(TMO), .COUNT_W(CW)) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .mem_req_i     (mem_req),
    .waitrequest_i (waitreq),
    .halt_i        (halt),
    .state_o       (state),
    .advance_o     (advance),
    .active_o      (active),
    .fault_o       (fault),
    .instr_count_o (icount),
    .stall_count_o (scount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_ic = 0; m_sc = 0; m_fault = 1'b0;
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_active", 32'(active), 1);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_icount", 32'(icount), 0);
    chk("rst_scount", 32'(scount), 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic mr, input logic wr, input logic h);
    logic m_stall;
    exp_t e, got;
    mem_req = mr; waitreq = wr; halt = h;
    #1;
    m_stall = mr & wr & (m_state != 3);
    chk("advance", 32'(advance), 32'((m_state != 3) && !m_stall));
    if (m_state != 3) begin
      if (m_stall) begin
        if (m_sc < SAT) m_sc++;
        if (m_wait == TMO - 1) begin
          m_state = 3; m_fault = 1'b1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else begin
        m_wait = 0;
        case (m_state)
          0: m_state = 1;
          1: m_state = 2;
          default: begin
            if (m_ic < SAT) m_ic++;
            m_state = h ? 3 : 0;
          end
        endcase
      end
    end
    e.st = 2'(m_state); e.act = (m_state != 3); e.flt = m_fault;
    e.ic = CW'(m_ic);   e.sc = CW'(m_sc);
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk("state", 32'(state), 32'(got.st));
    chk("active", 32'(active), 32'(got.act));
    chk("fault", 32'(fault), 32'(got.flt));
    chk("icount", 32'(icount), 32'(got.ic));
    chk("scount", 32'(scount), 32'(got.sc));
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // four clean instructions
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    chk("four_instr", 32'(icount), 4);
    chk("no_stalls", 32'(scount), 0);

    // three-cycle stall in FETCH, then completion with waitrequest low
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("fetch_hold", 32'(state), 0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("fetch_to_exec1", 32'(state), 1);
    chk("stall3", 32'(scount), 3);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // halt_i outside EXEC2 is ignored
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("no_halt_fetch", 32'(state), 0);

    // halt_i during a stalled EXEC2 is overridden by the releasing edge
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("stalled_halt_ignored", 32'(state), 0);

    // real halt, then frozen outputs
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("halted", 32'(state), 3);
    chk("halted_inactive", 32'(active), 0);
    chk("halt_retired", 32'(icount), 8);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // bus timeout in EXEC1
    #1;
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TMO; i++) step(1'b1, 1'b1, 1'b0);
    chk("timeout_halt", 32'(state), 3);
    chk("timeout_fault", 32'(fault), 1);
    chk("timeout_icount", 32'(icount), 0);
    chk("timeout_scount", 32'(scount), 4);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-stall clears the fault and restarts cleanly
    #1;
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("post_reset_instr", 32'(icount), 1);
    chk("post_reset_fault", 32'(fault), 0);

    // retire counter saturation
    for (int i = 0; i < 17 * 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("icount_saturated", 32'(icount), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
